// File: rtl/mult_result_accumulator.sv
// rtl/mult_result_accumulator.sv - batch accumulator and restart controller for the shift-add multiplier
// Captures each rising mult_rdy, sums N_ACC sign-extended products and presents the sum on valid/ready.
module mult_result_accumulator #(
  parameter int N_ACC  = 4,
  parameter int ACC_W  = 20,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [15:0]      mult_p,
  input  logic             mult_rdy,
  output logic             mult_clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_ACC + 1);
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rdy_q;
  logic             clr_q;
  logic             valid_q;
  logic             sat_q;
  logic             sat_d;
  logic [ACC_W-1:0] acc_out_q;
  logic [ACC_W:0]   sum;
  logic             capture;
  logic             cnt_done;

  // One guard bit above the accumulator makes overflow visible as sum[ACC_W] != sum[ACC_W-1].
  always_comb begin
    sum      = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-15){mult_p[15]}}, mult_p};
    acc_d    = sum[ACC_W-1:0];
    sat_d    = sat_q;
    if (SAT_EN && (sum[ACC_W] != sum[ACC_W-1])) begin
      acc_d = sum[ACC_W] ? SAT_MIN : SAT_MAX;
      sat_d = 1'b1;
    end
    cnt_d    = cnt_q + CNT_W'(1);
    cnt_done = (cnt_d == CNT_W'(N_ACC));
    capture  = (state_q == S_WAIT) && mult_rdy && !rdy_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      clr_q     <= 1'b0;
      valid_q   <= 1'b0;
      sat_q     <= 1'b0;
      acc_out_q <= '0;
    end else begin
      rdy_q <= mult_rdy;
      case (state_q)
        S_IDLE: begin
          if (en) begin
            state_q <= S_KICK;
            clr_q   <= 1'b1;
          end
        end
        S_KICK: begin
          clr_q   <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (capture) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (cnt_done) begin
              state_q   <= S_HOLD;
              valid_q   <= 1'b1;
              acc_out_q <= acc_d;
            end else begin
              state_q <= S_KICK;
              clr_q   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          // A finished batch is only released by the handshake; en is looked at here, not mid-batch.
          if (valid_q && out_ready) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            if (en) begin
              state_q <= S_KICK;
              clr_q   <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          clr_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mult_clr  = clr_q;
  assign acc_out   = acc_out_q;
  assign out_valid = valid_q;
  assign sat_flag  = sat_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_result_accumulator.sv
// tb/tb_mult_result_accumulator.sv - directed bench for mult_result_accumulator
// Three instances share stimulus: default (ACC_W=20, sat), ACC_W=17 saturating, ACC_W=17 wrapping.
module tb_mult_result_accumulator;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic [15:0] mult_p;
  logic mult_rdy;
  logic out_ready;

  logic clr_a, valid_a, sat_a, busy_a;
  logic signed [19:0] acc_a;
  logic clr_s, valid_s, sat_s, busy_s;
  logic signed [16:0] acc_s;
  logic clr_w, valid_w, sat_w, busy_w;
  logic signed [16:0] acc_w;

  int n_checks = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int base;

  always #5 clk = ~clk;

  always @(posedge clk) if (clr_a) clr_cnt <= clr_cnt + 1;

  mult_result_accumulator #(.N_ACC(4), .ACC_W(20), .SAT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .en(en), .mult_p(mult_p), .mult_rdy(mult_rdy),
    .mult_clr(clr_a), .acc_out(acc_a), .out_valid(valid_a), .out_ready(out_ready),
    .sat_flag(sat_a), .busy(busy_a)
  );

  mult_result_accumulator #(.N_ACC(4), .ACC_W(17), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .mult_p(mult_p), .mult_rdy(mult_rdy),
    .mult_clr(clr_s), .acc_out(acc_s), .out_valid(valid_s), .out_ready(out_ready),
    .sat_flag(sat_s), .busy(busy_s)
  );

  mult_result_accumulator #(.N_ACC(4), .ACC_W(17), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .mult_p(mult_p), .mult_rdy(mult_rdy),
    .mult_clr(clr_w), .acc_out(acc_w), .out_valid(valid_w), .out_ready(out_ready),
    .sat_flag(sat_w), .busy(busy_w)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clr(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (clr_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Behaves like the multiplier: cleared by mult_clr, then raises mult_rdy with a product a few cycles later.
  task automatic product(input logic [15:0] p);
    bit ok;
    wait_clr(ok);
    check("clr_seen", int'(ok), 1);
    mult_rdy = 1'b0;
    repeat (3) @(negedge clk);
    mult_p   = p;
    mult_rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid_a) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("valid_seen", int'(ok), 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; mult_p = '0; mult_rdy = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clr", int'(clr_a), 0);
    check("rst_valid", int'(valid_a), 0);
    check("rst_acc", int'(acc_a), 0);
    check("rst_sat", int'(sat_a), 0);
    check("rst_busy", int'(busy_a), 0);
    reset = 1'b0;
    @(negedge clk);

    // Mixed-sign products; exactly four restart pulses.
    base = clr_cnt;
    en = 1'b1;
    product(16'd15);
    product(-16'sd14);
    product(16'd16129);
    product(16'd16384);
    wait_valid();
    check("b1_acc", int'(acc_a), 32514);
    check("b1_sat", int'(sat_a), 0);
    check("b1_acc17", int'(acc_s), 32514);
    check("b1_clr_pulses", clr_cnt - base, 4);

    // Back-pressure with mult_rdy toggling in HOLD.
    base = clr_cnt;
    for (int i = 0; i < 10; i++) begin
      mult_rdy = ~mult_rdy;
      @(negedge clk);
    end
    mult_rdy = 1'b0;
    check("bp_acc", int'(acc_a), 32514);
    check("bp_valid", int'(valid_a), 1);
    check("bp_no_clr", clr_cnt - base, 0);
    check("bp_busy", int'(busy_a), 1);
    handshake();
    check("hs_valid", int'(valid_a), 0);
    check("hs_kick", int'(clr_a), 1);

    // Saturation vs wrap at ACC_W=17; en dropped after the 2nd capture.
    product(16'd16384);
    product(16'd16384);
    en = 1'b0;
    product(16'd16384);
    product(16'd16384);
    wait_valid();
    check("b2_acc", int'(acc_a), 65536);
    check("b2_sat", int'(sat_a), 0);
    check("b2_acc_sat", int'(acc_s), 65535);
    check("b2_sat_sat", int'(sat_s), 1);
    check("b2_acc_wrap", int'(acc_w), -65536);
    check("b2_sat_wrap", int'(sat_w), 0);
    check("b2_valid_wrap", int'(valid_w), 1);
    handshake();
    base = clr_cnt;
    repeat (10) @(negedge clk);
    check("endrop_busy", int'(busy_a), 0);
    check("endrop_valid", int'(valid_a), 0);
    check("endrop_no_clr", clr_cnt - base, 0);
    check("endrop_acc_hold", int'(acc_a), 65536);
    check("endrop_sat_clr", int'(sat_s), 0);

    // Async reset after the 3rd capture, then a clean batch.
    en = 1'b1;
    product(16'd100);
    product(16'd200);
    product(16'd300);
    #2 reset = 1'b1;
    #1;
    check("ar_clr", int'(clr_a), 0);
    check("ar_valid", int'(valid_a), 0);
    check("ar_acc", int'(acc_a), 0);
    check("ar_sat", int'(sat_a), 0);
    check("ar_busy", int'(busy_a), 0);
    @(negedge clk);
    reset = 1'b0;
    product(16'd1000);
    product(-16'sd2000);
    product(16'd3000);
    product(-16'sd4000);
    wait_valid();
    check("b3_acc", int'(acc_a), -2000);
    check("b3_acc_sat", int'(acc_s), -2000);
    check("b3_acc_wrap", int'(acc_w), -2000);
    check("b3_sat", int'(sat_s), 0);
    en = 1'b0;
    handshake();
    @(negedge clk);
    check("b3_idle", int'(busy_a), 0);

    // mult_rdy already high on WAIT entry must not count.
    mult_rdy = 1'b1;
    mult_p   = 16'd7;
    en       = 1'b1;
    base     = clr_cnt;
    begin
      bit ok;
      wait_clr(ok);
      check("hh_clr_seen", int'(ok), 1);
    end
    repeat (6) @(negedge clk);
    check("hh_no_capture", clr_cnt - base, 1);
    check("hh_busy", int'(busy_a), 1);
    check("hh_valid", int'(valid_a), 0);
    mult_rdy = 1'b0;
    @(negedge clk);
    mult_rdy = 1'b1;
    @(negedge clk);
    check("hh_recapture", int'(clr_a), 1);
    product(16'd8);
    product(16'd9);
    product(16'd10);
    wait_valid();
    check("b4_acc", int'(acc_a), 34);
    check("b4_clr_pulses", clr_cnt - base, 4);
    en = 1'b0;
    handshake();
    @(negedge clk);
    check("b4_idle", int'(busy_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
